iram_seq: RTL and testbench

IRAM_SEQ -- requirements
Module: iram_seq

---
 rtl/iram_seq_if.sv | 34 +++
 rtl/iram_seq.sv | 94 +++++++++
 tb/tb_iram_seq.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iram_seq_if.sv
// iram_seq_if: write, playback-control and network-facing signals of iram_seq.
// The master drives storage writes and playback requests; the slave presents sample vectors.
interface iram_seq_if #(
    parameter int DATA_W = 32,
    parameter int CH     = 7,
    parameter int DEPTH  = 16
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = CH > 1 ? $clog2(CH) : 1;
    localparam int NW = $clog2(DEPTH + 1);
    logic                   wr_en;
    logic [AW-1:0]          wr_smp;
    logic [CW-1:0]          wr_ch;
    logic [DATA_W-1:0]      wr_data;
    logic [NW-1:0]          smp_num;
    logic                   loop;
    logic                   start;
    logic                   abort;
    logic                   ack;
    logic [CH*DATA_W-1:0]   data_out;
    logic                   in_rdy;
    logic                   net_rst;
    logic                   busy;
    logic                   done;
    logic                   err;
    modport master (
        output wr_en, wr_smp, wr_ch, wr_data, smp_num, loop, start, abort, ack,
        input  data_out, in_rdy, net_rst, busy, done, err
    );
    modport slave (
        input  wr_en, wr_smp, wr_ch, wr_data, smp_num, loop, start, abort, ack,
        output data_out, in_rdy, net_rst, busy, done, err
    );
endinterface

// File: rtl/iram_seq.sv
// iram_seq: sample-vector store replayed into a network, with a clear pulse before each sample.
// Each sample is loaded into data_out during CLR and held in SHOW until ack.
module iram_seq #(
    parameter int DATA_W = 32,
    parameter int CH     = 7,
    parameter int DEPTH  = 16
) (
    input  logic       clk,
    input  logic       reset,
    iram_seq_if.slave  bus
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = CH > 1 ? $clog2(CH) : 1;
    localparam int NW = $clog2(DEPTH + 1);
    typedef enum logic [1:0] {IDLE, CLR, SHOW} state_t;
    state_t               state_q, state_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [NW-1:0]        num_q, num_d;
    logic                 loop_q, loop_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [CH*DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0]    mem [DEPTH][CH];
    logic                 wr_ok, num_ok, last;
    assign wr_ok  = bus.wr_en && state_q == IDLE
                    && ({1'b0, bus.wr_smp} < (AW+1)'(DEPTH))
                    && ({1'b0, bus.wr_ch} < (CW+1)'(CH));
    assign num_ok = bus.smp_num != '0 && bus.smp_num <= NW'(DEPTH);
    assign last   = NW'(idx_q) == num_q - NW'(1);
    // Storage is deliberately not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[bus.wr_smp][bus.wr_ch] <= bus.wr_data;
    end
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        num_d   = num_q;
        loop_d  = loop_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = bus.wr_en && !wr_ok;
        case (state_q)
            IDLE: if (bus.start) begin
                if (num_ok) begin
                    state_d = CLR;
                    idx_d   = '0;
                    num_d   = bus.smp_num;
                    loop_d  = bus.loop;
                end else err_d = 1'b1;
            end
            CLR: begin
                for (int c = 0; c < CH; c++) data_d[c*DATA_W +: DATA_W] = mem[idx_q][c];
                state_d = SHOW;
            end
            SHOW: if (bus.ack) begin
                state_d = last && !loop_q ? IDLE : CLR;
                idx_d   = last ? '0 : idx_q + 1'b1;
                done_d  = last && !loop_q;
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && bus.start) err_d = 1'b1;
        // Abort wins over a same-cycle ack and suppresses its done pulse.
        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            num_q   <= '0;
            loop_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            loop_q  <= loop_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
    assign bus.data_out = data_q;
    assign bus.in_rdy   = state_q == SHOW;
    assign bus.net_rst  = state_q == CLR;
    assign bus.busy     = state_q != IDLE;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_iram_seq.sv
// tb_iram_seq: directed scenario tasks for iram_seq with a small storage model.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that point.
module tb_iram_seq;
    localparam int DATA_W = 32;
    localparam int CH     = 7;
    localparam int DEPTH  = 16;
    localparam int VW     = CH * DATA_W;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [DATA_W-1:0] exp_mem [DEPTH][CH];
    iram_seq_if #(.DATA_W(DATA_W), .CH(CH), .DEPTH(DEPTH)) bus ();
    iram_seq #(.DATA_W(DATA_W), .CH(CH), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    function automatic logic [VW-1:0] vec(int s);
        logic [VW-1:0] v;
        for (int c = 0; c < CH; c++) v[c*DATA_W +: DATA_W] = exp_mem[s][c];
        return v;
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic start_play(int n, logic lp);
        bus.smp_num = 5'(n);
        bus.loop = lp;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask
    task automatic test_reset();
        checks++;
        if ({bus.data_out, bus.in_rdy, bus.net_rst, bus.busy, bus.done, bus.err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got in_rdy=%b net_rst=%b busy=%b done=%b err=%b data=%h, want all 0",
                     bus.in_rdy, bus.net_rst, bus.busy, bus.done, bus.err, bus.data_out);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask
    task automatic test_write();
        for (int s = 0; s < 3; s++)
            for (int c = 0; c < CH; c++) begin
                bus.wr_en = 1'b1;
                bus.wr_smp = 4'(s);
                bus.wr_ch = 3'(c);
                bus.wr_data = 32'(s * 16 + c);
                exp_mem[s][c] = 32'(s * 16 + c);
                tick();
                bus.wr_en = 1'b0;
                checks++;
                if (bus.err !== 1'b0) begin
                    failures++;
                    $display("FAIL write_err s=%0d c=%0d: got err=%b, want 0", s, c, bus.err);
                end
            end
    endtask
    task automatic test_playback();
        start_play(3, 1'b0);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({bus.net_rst, bus.in_rdy, bus.busy} !== 3'b101) begin
                failures++;
                $display("FAIL play_clr s=%0d: got net_rst,in_rdy,busy=%b, want 101", s, {bus.net_rst, bus.in_rdy, bus.busy});
            end
            tick();
            checks++;
            if (bus.in_rdy !== 1'b1 || bus.net_rst !== 1'b0 || bus.data_out !== vec(s)) begin
                failures++;
                $display("FAIL play_show s=%0d: got in_rdy=%b data=%h, want 1 %h", s, bus.in_rdy, bus.data_out, vec(s));
            end
            tick();
            checks++;
            if (bus.in_rdy !== 1'b1 || bus.data_out !== vec(s) || bus.done !== 1'b0) begin
                failures++;
                $display("FAIL play_hold s=%0d: got in_rdy=%b done=%b data=%h, want 1 0 %h", s, bus.in_rdy, bus.done, bus.data_out, vec(s));
            end
            bus.ack = 1'b1;
            tick();
            bus.ack = 1'b0;
        end
        checks++;
        if ({bus.done, bus.busy, bus.in_rdy} !== 3'b100) begin
            failures++;
            $display("FAIL play_done: got done,busy,in_rdy=%b, want 100", {bus.done, bus.busy, bus.in_rdy});
        end
        tick();
        checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            failures++;
            $display("FAIL play_done_pulse: got done,busy=%b, want 00", {bus.done, bus.busy});
        end
    endtask
    task automatic test_loop();
        bus.ack = 1'b1;
        start_play(2, 1'b1);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (bus.net_rst !== 1'b1 || bus.in_rdy !== 1'b0) begin
                failures++;
                $display("FAIL loop_clr k=%0d: got net_rst=%b in_rdy=%b, want 1 0", k, bus.net_rst, bus.in_rdy);
            end
            tick();
            checks++;
            if (bus.in_rdy !== 1'b1 || bus.done !== 1'b0 || bus.data_out !== vec(k % 2)) begin
                failures++;
                $display("FAIL loop_show k=%0d: got in_rdy=%b done=%b data=%h, want 1 0 %h", k, bus.in_rdy, bus.done, bus.data_out, vec(k % 2));
            end
            tick();
        end
        tick();
        bus.ack = 1'b0;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if ({bus.in_rdy, bus.busy, bus.net_rst, bus.done} !== 4'b0000) begin
            failures++;
            $display("FAIL loop_abort: got in_rdy,busy,net_rst,done=%b, want 0000", {bus.in_rdy, bus.busy, bus.net_rst, bus.done});
        end
    endtask
    task automatic test_err();
        start_play(0, 1'b0);
        checks++;
        if ({bus.err, bus.busy} !== 2'b10) begin
            failures++;
            $display("FAIL err_num0: got err,busy=%b, want 10", {bus.err, bus.busy});
        end
        start_play(DEPTH + 1, 1'b0);
        checks++;
        if ({bus.err, bus.busy} !== 2'b10) begin
            failures++;
            $display("FAIL err_num_big: got err,busy=%b, want 10", {bus.err, bus.busy});
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if ({bus.err, bus.busy} !== 2'b00) begin
            failures++;
            $display("FAIL err_idle_abort: got err,busy=%b, want 00", {bus.err, bus.busy});
        end
        bus.wr_en = 1'b1;
        bus.wr_smp = 4'd0;
        bus.wr_ch = 3'd7;
        bus.wr_data = 32'hBAD0BAD0;
        tick();
        bus.wr_en = 1'b0;
        checks++;
        if (bus.err !== 1'b1) begin
            failures++;
            $display("FAIL err_bad_ch: got err=%b, want 1", bus.err);
        end
    endtask
    task automatic test_wr_busy();
        start_play(1, 1'b0);
        tick();
        bus.wr_en = 1'b1;
        bus.wr_smp = 4'd0;
        bus.wr_ch = 3'd2;
        bus.wr_data = 32'hDEADBEEF;
        bus.start = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (bus.err !== 1'b1 || bus.in_rdy !== 1'b1 || bus.data_out !== vec(0)) begin
            failures++;
            $display("FAIL busy_write: got err=%b in_rdy=%b data=%h, want 1 1 %h", bus.err, bus.in_rdy, bus.data_out, vec(0));
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        start_play(1, 1'b0);
        tick();
        checks++;
        if (bus.data_out !== vec(0)) begin
            failures++;
            $display("FAIL busy_write_replay: got data=%h, want %h", bus.data_out, vec(0));
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask
    task automatic test_same_cycle();
        bus.wr_en = 1'b1;
        bus.wr_smp = 4'd0;
        bus.wr_ch = 3'd3;
        bus.wr_data = 32'h0000ABCD;
        exp_mem[0][3] = 32'h0000ABCD;
        start_play(1, 1'b0);
        bus.wr_en = 1'b0;
        tick();
        checks++;
        if (bus.data_out !== vec(0) || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL wr_start_same: got err=%b data=%h, want 0 %h", bus.err, bus.data_out, vec(0));
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        tick();
    endtask
    task automatic test_abort_ack();
        start_play(1, 1'b0);
        tick();
        bus.ack = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.ack = 1'b0;
        bus.abort = 1'b0;
        checks++;
        if ({bus.done, bus.busy, bus.in_rdy} !== 3'b000) begin
            failures++;
            $display("FAIL abort_ack: got done,busy,in_rdy=%b, want 000", {bus.done, bus.busy, bus.in_rdy});
        end
        tick();
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL abort_ack_late: got done=%b, want 0", bus.done);
        end
    endtask
    task automatic test_reset_mid();
        start_play(3, 1'b0);
        tick();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        tick();
        checks++;
        if (bus.in_rdy !== 1'b1 || bus.data_out !== vec(1)) begin
            failures++;
            $display("FAIL mid_show1: got in_rdy=%b data=%h, want 1 %h", bus.in_rdy, bus.data_out, vec(1));
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({bus.data_out, bus.in_rdy, bus.net_rst, bus.busy, bus.done, bus.err} !== '0) begin
            failures++;
            $display("FAIL mid_reset_async: got in_rdy=%b net_rst=%b busy=%b done=%b data=%h, want all 0",
                     bus.in_rdy, bus.net_rst, bus.busy, bus.done, bus.data_out);
        end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            failures++;
            $display("FAIL mid_reset_done: got done,busy=%b, want 00", {bus.done, bus.busy});
        end
        start_play(3, 1'b0);
        tick();
        checks++;
        if (bus.in_rdy !== 1'b1 || bus.data_out !== vec(0)) begin
            failures++;
            $display("FAIL mid_reset_replay: got in_rdy=%b data=%h, want 1 %h", bus.in_rdy, bus.data_out, vec(0));
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask
    initial begin
        bus.wr_en = 1'b0;
        bus.wr_smp = '0;
        bus.wr_ch = '0;
        bus.wr_data = '0;
        bus.smp_num = '0;
        bus.loop = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.ack = 1'b0;
        #2;
        test_reset();
        test_write();
        test_playback();
        test_loop();
        test_err();
        test_wr_busy();
        test_same_cycle();
        test_abort_ack();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
